disco_regfile: RTL and testbench
================================

Name: disco_regfile

Overview:
- Parametrised TRM register file for the disco core, generalised in register count, data width and read-port count.
- R0 is hardwired to zero. Configurable reset values for SP (R14) and FP (R13).
- Write-to-read bypass, plus a pending-load scoreboard so the issue stage can stall on a busy source register.
- Sits between decode/issue and writeback.

Parameters:
- NREGS, 16, number of architectural registers; power of two, >= 16.
- XLEN, 32, data width in bits.
- NRD, 2, number of combinational read ports, 1..4.
- SP_RESET, 32'h0000_FFFC, reset value of R14 (SP); truncated to XLEN.
- FP_RESET, 32'h0000_FFFC, reset value of R13 (FP); truncated to XLEN.
- Derived: AW = $clog2(NREGS).

Ports:
- clk  in  1  core clock; everything samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  per port: source register has a load outstanding.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination register.
- wr_data  in  XLEN  writeback value.
- wr_clr  in  1  writeback completes a pending load (clears scoreboard bit).
- sb_set  in  1  issue stage marks a register pending (load issued).
- sb_addr  in  AW  register to mark pending.
- flush  in  1  clear the whole scoreboard (pipeline flush); register data is kept.
- busy_any  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (rst=1 at an edge):
  - All registers go to 0, except R13=FP_RESET and R14=SP_RESET.
  - Scoreboard goes to all zeros.
  - Visible next cycle: rd_data reads these values, rd_busy=0, busy_any=0.
  - rst has priority over wr_en, sb_set and flush in the same cycle.
- Reads:
  - Combinational, zero latency.
  - rd_addr=0 always returns 0 and rd_busy=0, regardless of writes or scoreboard state.
- Write:
  - When wr_en=1 and wr_addr!=0, the register updates at the edge.
  - wr_addr=0 is silently dropped.
- Bypass:
  - If wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr in the same cycle, rd_data[i]=wr_data (new value, not the stored one).
  - Applies independently to every read port.
- Scoreboard, one bit per register (bit 0 is constant 0). Next-state per bit r:
  - flush=1: 0 for all r, then the sb_set term below is applied on top.
  - Otherwise: busy'[r] = (busy[r] & ~(wr_en & wr_clr & wr_addr==r)) | (sb_set & sb_addr==r & r!=0).
  - Simultaneous clear and set on the same register: set wins, so the bit stays 1 (a back-to-back load to the same destination).
  - flush together with sb_set: only sb_addr ends up busy (the new load issues after the flush).
- rd_busy[i]:
  - Equals busy[rd_addr[i]] & ~(wr_en & wr_clr & wr_addr==rd_addr[i]).
  - This bypasses the clear, so there is no extra stall cycle.
  - It is not raised by an sb_set in the same cycle; the set is visible from the next cycle.
- busy_any:
  - Registered view: OR of the current scoreboard bits. No bypass.
- wr_en=1 with wr_clr=0 on a busy register:
  - Data is written and the bit stays set.
  - Legal (an ALU write racing a load); the issue stage avoids it. No assertion in RTL; the bench checks it is never issued.
- Width rules:
  - Addresses are AW bits.
  - For XLEN<32, reset constants are truncated to the low XLEN bits.
  - No sign handling inside the block.
- Reset mid-operation: any outstanding scoreboard bits and writes in the reset cycle are discarded.

Decomposition:
- Extend the disco package with:
  - Named register indices: R0..R15, SP, FP, LR, V0..V8.
  - localparam DISCO_NREGS=16 and DISCO_XLEN=32.
  - A function reg_is_zero(addr).
- Sub-module disco_scoreboard (NREGS): owns the busy vector, set/clear/flush priority and busy_any.
- disco_regfile instantiates disco_scoreboard and holds the storage array and bypass muxes.

Test Plan:
- Reset and R0 check:
  - After rst, read R14, R13, R5, R0 → SP_RESET, FP_RESET, 0, 0.
  - Write 32'hDEAD_BEEF to R0, then read R0 → 0.
- Bypass:
  - wr_en=1, wr_addr=3, wr_data=32'h1234 with rd_addr[0]=rd_addr[1]=3 in the same cycle → both ports read 32'h1234 that cycle.
  - Next cycle with wr_en=0 → still 32'h1234.
- Scoreboard set and clear:
  - sb_set R7 → next cycle rd_busy=1 on R7 and busy_any=1.
  - Writeback R7 with wr_clr=1 and data 32'h55 → that cycle rd_busy=0 and rd_data=32'h55; next cycle busy_any=0.
- Set/clear collision:
  - R9 busy; same cycle: wr_clr on R9 and sb_set on R9 → next cycle R9 is still busy.
- Flush:
  - R2, R4, R6 busy; flush=1 with sb_set R8 → next cycle only R8 is busy.
- Mid-operation reset:
  - R10 busy and wr_en to R10 asserted during rst → next cycle R10=0, rd_busy=0, busy_any=0.
- Run the full set at NREGS=32, XLEN=16, NRD=3.

Source files
------------

// File: rtl/disco_pkg.sv
// Shared definitions for the disco core register file.
// Contents:
//   DISCO_NREGS / DISCO_XLEN : default architectural register count and width
//   R0..R15, SP, FP, LR, V0..V8 : named register indices
//   reg_is_zero()           : true when an address selects the hardwired R0
package disco_pkg;

    localparam int DISCO_NREGS = 16;
    localparam int DISCO_XLEN  = 32;

    localparam int unsigned R0  = 0;
    localparam int unsigned R1  = 1;
    localparam int unsigned R2  = 2;
    localparam int unsigned R3  = 3;
    localparam int unsigned R4  = 4;
    localparam int unsigned R5  = 5;
    localparam int unsigned R6  = 6;
    localparam int unsigned R7  = 7;
    localparam int unsigned R8  = 8;
    localparam int unsigned R9  = 9;
    localparam int unsigned R10 = 10;
    localparam int unsigned R11 = 11;
    localparam int unsigned R12 = 12;
    localparam int unsigned R13 = 13;
    localparam int unsigned R14 = 14;
    localparam int unsigned R15 = 15;

    localparam int unsigned FP  = R13;
    localparam int unsigned SP  = R14;
    localparam int unsigned LR  = R15;

    // Value/argument registers occupy R1..R9.
    localparam int unsigned V0  = R1;
    localparam int unsigned V1  = R2;
    localparam int unsigned V2  = R3;
    localparam int unsigned V3  = R4;
    localparam int unsigned V4  = R5;
    localparam int unsigned V5  = R6;
    localparam int unsigned V6  = R7;
    localparam int unsigned V7  = R8;
    localparam int unsigned V8  = R9;

    // Callers zero-extend their AW-bit address to 32 bits.
    function automatic logic reg_is_zero(input logic [31:0] addr);
        return addr == 32'd0;
    endfunction

endpackage

// File: rtl/disco_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   set, set_addr : mark a register pending (load issued)
//   clr, clr_addr : clear a register's pending bit (load writeback)
//   flush         : drop every pending bit; a same-cycle set still applies
//   busy          : registered busy vector, bit 0 always 0
//   busy_any      : OR of the registered busy vector
module disco_scoreboard #(
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             busy_any
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is OR-ed in last so a clear+set on the same register keeps it busy
    // (back-to-back loads to one destination), and a flush never cancels the
    // load that issues alongside it.
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_d[r] = (flush ? 1'b0 : (busy_q[r] & ~(clr && clr_addr == AW'(r))))
                      | (set && set_addr == AW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy     = busy_q;
    assign busy_any = |busy_q;

endmodule

// File: rtl/disco_regfile.sv
// disco core register file: NREGS x XLEN storage, NRD combinational read
// ports with write-to-read bypass, and a pending-load scoreboard.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rd_addr[i*AW+:AW] : read address of port i
//   rd_data[i*XLEN+:XLEN] : read data of port i (bypassed from writeback)
//   rd_busy[i]        : source of port i has a load outstanding
//   wr_en/addr/data   : writeback; writes to R0 are dropped
//   wr_clr            : this writeback completes a pending load
//   sb_set, sb_addr   : issue marks a destination pending
//   flush             : clear the scoreboard, keep register data
//   busy_any          : any register pending (registered, no bypass)
module disco_regfile
    import disco_pkg::*;
#(
    parameter int          NREGS    = DISCO_NREGS,
    parameter int          XLEN     = DISCO_XLEN,
    parameter int          NRD      = 2,
    parameter logic [31:0] SP_RESET = 32'h0000_FFFC,
    parameter logic [31:0] FP_RESET = 32'h0000_FFFC,
    localparam int         AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                wr_clr,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush,
    output logic                busy_any
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_ok;
    logic             clr_en;

    function automatic logic [XLEN-1:0] rst_val(input int r);
        if (r == int'(SP)) return XLEN'(SP_RESET);
        if (r == int'(FP)) return XLEN'(FP_RESET);
        return '0;
    endfunction

    assign wr_ok  = wr_en && !reg_is_zero(32'(wr_addr));
    assign clr_en = wr_en && wr_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= rst_val(r);
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    disco_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set      (sb_set),
        .set_addr (sb_addr),
        .clr      (clr_en),
        .clr_addr (wr_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_any (busy_any)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          zero;
        logic          hit;
        assign a    = rd_addr[i*AW +: AW];
        assign zero = reg_is_zero(32'(a));
        assign hit  = wr_en && (wr_addr == a);
        assign rd_data[i*XLEN +: XLEN] = zero ? '0 : (hit ? wr_data : regs[a]);
        // Scoreboard bit 0 is constant 0, so R0 never reports busy. The
        // clear is bypassed so a consumer issues in the writeback cycle.
        assign rd_busy[i] = busy[a] & ~(clr_en && wr_addr == a);
    end

endmodule

// File: tb/tb_disco_regfile.sv
module tb_disco_regfile;
    localparam int          NREGS    = 32;
    localparam int          XLEN     = 16;
    localparam int          NRD      = 3;
    localparam int          AW       = $clog2(NREGS);
    localparam logic [31:0] SP_RESET = 32'h0000_FFFC;
    localparam logic [31:0] FP_RESET = 32'h0000_FFFC;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                wr_clr;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                flush;
    logic                busy_any;

    disco_regfile #(
        .NREGS(NREGS), .XLEN(XLEN), .NRD(NRD),
        .SP_RESET(SP_RESET), .FP_RESET(FP_RESET)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_clr(wr_clr), .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush),
        .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    // Reference state: register contents and the set of pending registers.
    logic [XLEN-1:0] mregs [NREGS];
    bit              mbusy [NREGS];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return mregs[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (wr_en && wr_clr && int'(wr_addr) == a) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic bit any_busy();
        for (int r = 0; r < NREGS; r++) if (mbusy[r]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int port_addr(input int i);
        logic [NRD*AW-1:0] v;
        v = rd_addr;
        return int'(v[i*AW +: AW]);
    endfunction

    // Model update at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mregs[r] = '0;
                mbusy[r] = 0;
            end
            mregs[13] = SP_RESET[XLEN-1:0] & '1;
            mregs[13] = FP_RESET[XLEN-1:0];
            mregs[14] = SP_RESET[XLEN-1:0];
        end else begin
            if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) mbusy[r] = 0;
            end else if (wr_en && wr_clr) begin
                mbusy[wr_addr] = 0;
            end
            if (sb_set && sb_addr != 0) mbusy[sb_addr] = 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(exp_data(port_addr(i))));
                chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_busy(port_addr(i))));
            end
            chk("busy_any", 64'(busy_any), 64'(any_busy()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_clr = 0;
        sb_set = 0; sb_addr = '0; flush = 0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d, input bit c);
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_clr = c;
    endtask

    task automatic sb(input int a);
        sb_set = 1; sb_addr = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] port(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    initial begin
        idle();
        rst = 1;
        set_rd(0, 0, 0);
        cyc();
        chk_on = 1;

        // Reset values.
        cyc(); idle(); set_rd(14, 13, 5);
        @(negedge clk);
        chk("sp_reset", 64'(port(0)), 64'h0000_FFFC & 64'hFFFF);
        chk("fp_reset", 64'(port(1)), 64'hFFFC);
        chk("r5_reset", 64'(port(2)), 64'h0);
        chk("busy_rst", 64'(rd_busy), 64'h0);
        chk("any_rst",  64'(busy_any), 64'h0);

        // R0 is hardwired.
        cyc(); set_rd(0, 0, 0); wr(0, 16'hBEEF, 0);
        @(negedge clk);
        chk("r0_wr_cycle", 64'(port(0)), 64'h0);
        cyc(); idle();
        @(negedge clk);
        chk("r0_after_wr", 64'(port(1)), 64'h0);

        // Bypass on every port, then stored value.
        cyc(); set_rd(3, 3, 3); wr(3, 16'h1234, 0);
        @(negedge clk);
        chk("byp_p0", 64'(port(0)), 64'h1234);
        chk("byp_p1", 64'(port(1)), 64'h1234);
        chk("byp_p2", 64'(port(2)), 64'h1234);
        cyc(); idle();
        @(negedge clk);
        chk("stored_r3", 64'(port(0)), 64'h1234);

        // Scoreboard set, not visible in the set cycle.
        cyc(); set_rd(7, 0, 3); sb(7);
        @(negedge clk);
        chk("set_same_cycle", 64'(rd_busy[0]), 64'h0);
        cyc(); idle();
        @(negedge clk);
        chk("r7_busy", 64'(rd_busy[0]), 64'h1);
        chk("any_r7",  64'(busy_any), 64'h1);
        chk("r0_never_busy", 64'(rd_busy[1]), 64'h0);
        // Clearing writeback: bypassed busy and data.
        cyc(); wr(7, 16'h0055, 1);
        @(negedge clk);
        chk("clr_byp_busy", 64'(rd_busy[0]), 64'h0);
        chk("clr_byp_data", 64'(port(0)), 64'h55);
        chk("any_clr_cycle", 64'(busy_any), 64'h1);
        cyc(); idle();
        @(negedge clk);
        chk("any_after_clr", 64'(busy_any), 64'h0);

        // Set/clear collision keeps R9 busy.
        cyc(); set_rd(9, 9, 9); sb(9);
        cyc(); idle(); wr(9, 16'h0099, 1); sb(9);
        cyc(); idle();
        @(negedge clk);
        chk("collide_busy", 64'(rd_busy[0]), 64'h1);
        cyc(); wr(9, 16'h0999, 1);
        cyc(); idle();

        // Flush with a simultaneous set.
        sb(2); cyc(); sb(4); cyc(); sb(6);
        cyc(); idle(); flush = 1; sb(8); set_rd(2, 4, 6);
        cyc(); idle();
        @(negedge clk);
        chk("flush_r2_r4_r6", 64'(rd_busy), 64'h0);
        chk("flush_any", 64'(busy_any), 64'h1);
        cyc(); set_rd(8, 2, 0);
        @(negedge clk);
        chk("flush_r8", 64'(rd_busy[0]), 64'h1);
        cyc(); idle(); wr(8, 16'h0008, 1);

        // Reset mid-operation discards the busy bit and the write.
        cyc(); idle(); sb(10); set_rd(10, 3, 14);
        cyc(); idle(); rst = 1; wr(10, 16'h7777, 1); sb(11);
        cyc(); idle();
        @(negedge clk);
        chk("rst_r10_data", 64'(port(0)), 64'h0);
        chk("rst_r10_busy", 64'(rd_busy[0]), 64'h0);
        chk("rst_any",      64'(busy_any), 64'h0);
        chk("rst_r3_data",  64'(port(1)), 64'h0);
        chk("rst_sp",       64'(port(2)), 64'hFFFC);

        // Randomised traffic; the issue stage never sends a non-clearing
        // write to a pending register.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            idle();
            rst = ($urandom_range(0, 199) == 0);
            rd_addr = NRD*AW'($urandom);
            for (int i = 0; i < NRD; i++)
                if ($urandom_range(0, 3) == 0) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wr_en   = 1;
                wr_addr = AW'($urandom);
                wr_data = XLEN'($urandom);
                wr_clr  = mbusy[wr_addr] ? 1'b1 : 1'($urandom);
                if ($urandom_range(0, 2) == 0 && port_addr(0) != 0) wr_addr = AW'(port_addr(0));
                if (mbusy[wr_addr]) wr_clr = 1;
            end
            if ($urandom_range(0, 2) == 0) begin
                sb_set  = 1;
                sb_addr = AW'($urandom);
            end
            flush = ($urandom_range(0, 39) == 0);
        end

        cyc(); idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
